// File: rtl/restoring_divider_if.sv
// rtl/restoring_divider_if.sv - request/result bundle for the restoring divider
interface restoring_divider_if #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
);
  logic             start;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
module restoring_divider #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  restoring_divider_if.slave    bus
);
  localparam int CNT_W = $clog2(DVD_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [DVD_W-1:0] dvd_r;      // remaining dividend bits, consumed from the MSB
  logic [DVS_W-1:0] dvs_r;
  logic [DVS_W:0]   prem;       // partial remainder, one bit wider than the divisor
  logic [DVD_W-1:0] quo_acc;    // quotient being built; outputs only see it at DONE entry
  logic [CNT_W-1:0] cnt;
  logic [DVD_W-1:0] quotient_r;
  logic [DVS_W-1:0] remainder_r;
  logic             dbz_r;
  logic             busy_c, done_c;

  logic [DVS_W:0]   shifted;
  logic [DVS_W+1:0] trial;      // extra MSB acts as the sign of the trial subtraction
  logic             qbit;
  logic [DVS_W:0]   next_prem;
  logic             last_step;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore
  always_comb begin
    shifted   = {prem[DVS_W-1:0], dvd_r[DVD_W-1]};
    trial     = {1'b0, shifted} - {2'b00, dvs_r};
    qbit      = ~trial[DVS_W+1];
    next_prem = qbit ? trial[DVS_W:0] : shifted;
    last_step = (cnt == CNT_W'(DVD_W - 1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state and status outputs; a zero divisor skips the iterations entirely
  always_comb begin
    next_state = state;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) next_state = (bus.divisor == '0) ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        busy_c = 1'b1;
        if (last_step) next_state = ST_DONE;
      end
      ST_DONE: begin
        done_c     = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_r       <= '0;
      dvs_r       <= '0;
      prem        <= '0;
      quo_acc     <= '0;
      cnt         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            dvd_r   <= bus.dividend;
            dvs_r   <= bus.divisor;
            prem    <= '0;
            quo_acc <= '0;
            cnt     <= '0;
            dbz_r   <= 1'b0;
            if (bus.divisor == '0) begin
              quotient_r  <= '1;
              remainder_r <= '0;
              dbz_r       <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          dvd_r   <= {dvd_r[DVD_W-2:0], 1'b0};
          prem    <= next_prem;
          quo_acc <= {quo_acc[DVD_W-2:0], qbit};
          cnt     <= cnt + CNT_W'(1);
          if (last_step) begin
            quotient_r  <= {quo_acc[DVD_W-2:0], qbit};
            remainder_r <= next_prem[DVS_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - directed and sweep checks for restoring_divider
module tb_restoring_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  restoring_divider_if #(.DVD_W(8), .DVS_W(4)) bus ();

  restoring_divider #(.DVD_W(8), .DVS_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [12:0] res;
  logic        got_done;
  int          lat, nbusy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] golden(input int a, input int b);
    logic [7:0] q;
    logic [3:0] r;
    if (b == 0) return {8'hFF, 4'h0, 1'b1};
    q = 8'(a / b);
    r = 4'(a % b);
    return {q, r, 1'b0};
  endfunction

  // Issue one request and wait (bounded) for done; lat counts edges after the accepting edge
  task automatic do_div(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0; nbusy = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    res      = {bus.quotient, bus.remainder, bus.div_by_zero};
    got_done = bus.done;
  endtask

  initial begin
    int ndone, t1, t2, cyc;
    logic prev;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero}, 0);
    rst = 1'b0;

    do_div(8'd200, 4'd7);
    check("200/7_done", got_done, 1);
    check("200/7_latency", lat, 8);
    check("200/7_busy_cycles", nbusy, 8);
    check("200/7_result", res, {8'd28, 4'd4, 1'b0});
    @(negedge clk);
    check("200/7_done_width", bus.done, 0);

    do_div(8'd5, 4'd9);
    check("5/9_result", res, {8'd0, 4'd5, 1'b0});
    do_div(8'd255, 4'd1);
    check("255/1_result", res, {8'd255, 4'd0, 1'b0});
    do_div(8'd255, 4'd15);
    check("255/15_result", res, {8'd17, 4'd0, 1'b0});

    do_div(8'd77, 4'd0);
    check("77/0_latency", lat, 0);
    check("77/0_busy_cycles", nbusy, 0);
    check("77/0_result", res, {8'hFF, 4'h0, 1'b1});
    repeat (4) @(negedge clk);
    check("77/0_hold", {bus.quotient, bus.remainder, bus.div_by_zero}, {8'hFF, 4'h0, 1'b1});

    // Results must hold during the next operation; the zero flag clears on accept
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 4'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_during_busy", {bus.quotient, bus.remainder, bus.div_by_zero}, {8'hFF, 4'h0, 1'b0});
    ndone = 0;
    while (!bus.done && ndone < 20) begin @(negedge clk); ndone++; end
    check("100/5_result", {bus.quotient, bus.remainder, bus.div_by_zero}, {8'd20, 4'd0, 1'b0});

    // A second start while busy is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk); @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0; res = '0;
    repeat (14) begin
      if (bus.done) begin ndone++; res = {bus.quotient, bus.remainder, bus.div_by_zero}; end
      @(negedge clk);
    end
    check("ignored_start_pulses", ndone, 1);
    check("ignored_start_result", res, {8'd28, 4'd4, 1'b0});

    // Reset in the middle of BUSY aborts without a done pulse
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero}, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      if (bus.done) ndone++;
      @(negedge clk);
    end
    check("no_done_after_abort", ndone, 0);
    do_div(8'd100, 4'd10);
    check("100/10_after_reset", res, {8'd10, 4'd0, 1'b0});

    // Back-to-back period with start held high
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
    t1 = -1; t2 = -1; prev = 1'b0; ndone = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus.done && prev) ndone++;
      if (bus.done && !prev) begin
        if (t1 < 0) t1 = cyc;
        else if (t2 < 0) t2 = cyc;
      end
      prev = bus.done;
    end
    bus.start = 1'b0;
    check("back_to_back_period", t2 - t1, 10);
    check("back_to_back_pulse_width", ndone, 0);
    repeat (12) @(negedge clk);

    // Full operand sweep against the golden model
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(8'(a), 4'(b));
        check($sformatf("sweep_%0d/%0d", a, b), {got_done, res}, {1'b1, golden(a, b)});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
